// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the master and slave blocks.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        WAIT_STOP
    } slave_state_t;

    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;
    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_slave_if.sv
// Byte-level handshake between the I2C target and the register side.
interface i2c_slave_if;

    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_load;
    logic       rw;
    logic       busy;

    modport slave (
        input  tx_data,
        output rx_data,
        output rx_valid,
        output tx_load,
        output rw,
        output busy
    );

    modport master (
        output tx_data,
        input  rx_data,
        input  rx_valid,
        input  tx_load,
        input  rw,
        input  busy
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into clk and produces one-clk edge, START and STOP pulses.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Idle bus level is high, so reset to 1 to avoid phantom edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: fixed 7-bit address, byte write with ACK, byte read until NACK,
// no clock stretching. SDA is open-drain, driven only low.
//   state     | meaning
//   IDLE      | bus free, waiting for START
//   ADDR      | shifting in address + R/W
//   ADDR_ACK  | driving ACK for a matching address
//   RX_BYTE   | shifting in a write byte
//   RX_ACK    | driving ACK for a received byte
//   TX_BYTE   | presenting a read byte MSB-first
//   TX_ACK    | sampling master ACK/NACK
//   WAIT_STOP | not addressed, ignoring bus until START/STOP
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl,
    inout  wire         sda,
    i2c_slave_if.slave  bus
);

    logic scl_rise, scl_fall, sda_s, start_det, stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    slave_state_t state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         phase_q, phase_d;
    logic         sda_low_q, sda_low_d;
    logic [7:0]   rx_data_q, rx_data_d;
    logic         rx_valid_q, rx_valid_d;
    logic         tx_load_q, tx_load_d;
    logic         rw_q, rw_d;
    logic         busy_q, busy_d;
    logic [7:0]   shift_in;
    logic         load_tx;

    assign shift_in = {shift_q[6:0], sda_s};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        phase_d    = phase_q;
        sda_low_d  = sda_low_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;
        rw_d       = rw_q;
        busy_d     = busy_q;
        load_tx    = 1'b0;

        // Bus conditions take priority over any SCL edge in the same cycle.
        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            sda_low_d = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_in[7:1] == SLAVE_ADDR) begin
                                rw_d    = shift_in[0];
                                busy_d  = 1'b1;
                                phase_d = 1'b0;
                                state_d = ADDR_ACK;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = WAIT_STOP;
                            end
                        end
                    end
                end
                ADDR_ACK, RX_ACK: begin
                    // First fall opens the ACK slot, second fall closes it.
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_low_d = 1'b1;
                            phase_d   = 1'b1;
                        end else if (state_q == ADDR_ACK && rw_q == I2C_RW_READ) begin
                            load_tx = 1'b1;
                        end else begin
                            sda_low_d = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = RX_BYTE;
                        end
                    end
                end
                RX_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                            phase_d    = 1'b0;
                            state_d    = RX_ACK;
                        end
                    end
                end
                TX_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_low_d = 1'b0;
                            phase_d   = 1'b0;
                            state_d   = TX_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_low_d = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_NACK) begin
                            state_d = WAIT_STOP;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        load_tx = 1'b1;
                    end
                end
                IDLE, WAIT_STOP: ;
                default: state_d = IDLE;
            endcase
        end

        if (load_tx) begin
            tx_load_d = 1'b1;
            shift_d   = bus.tx_data;
            sda_low_d = ~bus.tx_data[7];
            bit_cnt_d = 3'd0;
            state_d   = TX_BYTE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            phase_q    <= 1'b0;
            sda_low_q  <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            phase_q    <= phase_d;
            sda_low_q  <= sda_low_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_load_q  <= tx_load_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
        end
    end

    assign sda          = sda_low_q ? 1'b0 : 1'bz;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.tx_load  = tx_load_q;
    assign bus.rw       = rw_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed and randomized I2C transactions against the i2c_slave target,
// with the bench acting as bus master and register-side byte source.
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam int Q = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic m_sda_low = 1'b0;
    wire  sda;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave_if bus_if ();

    logic [7:0] tx_arr [64];
    int tx_pops = 0;
    int rx_cnt = 0;
    int tgt_low = 0;
    int overlap = 0;
    int outside = 0;
    int n_checks = 0;
    int n_pass = 0;

    assign bus_if.tx_data = tx_arr[tx_pops[5:0]];

    i2c_slave #(
        .SLAVE_ADDR  (7'h42),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .scl (scl),
        .sda (sda),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.tx_load) tx_pops++;
        if (bus_if.rx_valid) rx_cnt++;
        if (bus_if.rx_valid && bus_if.tx_load) overlap++;
        if ((bus_if.rx_valid || bus_if.tx_load) && !bus_if.busy) outside++;
        if (sda === 1'b0 && !m_sda_low) tgt_low++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic m_bit(input logic b, output logic got);
        wait_q();
        m_sda_low = ~b;
        wait_q();
        scl = 1'b1;
        wait_q();
        got = sda;
        wait_q();
        scl = 1'b0;
    endtask

    task automatic m_start();
        if (scl == 1'b0) begin
            wait_q();
            m_sda_low = 1'b0;
            wait_q();
            scl = 1'b1;
            wait_q();
        end
        m_sda_low = 1'b1;
        wait_q();
        scl = 1'b0;
    endtask

    task automatic m_stop();
        wait_q();
        m_sda_low = 1'b1;
        wait_q();
        scl = 1'b1;
        wait_q();
        m_sda_low = 1'b0;
        wait_q();
    endtask

    task automatic m_write(input logic [7:0] b, output logic acked);
        logic g;
        for (int i = 7; i >= 0; i--) m_bit(b[i], g);
        m_bit(1'b1, g);
        acked = ~g;
    endtask

    task automatic m_read(input logic ack, output logic [7:0] b, output logic slot);
        logic g;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, g);
            b[i] = g;
        end
        m_bit(~ack, slot);
    endtask

    initial begin
        logic ack, s, g, is_rd, match;
        logic [7:0] d, bv;
        logic [6:0] a;
        logic [7:0] exp_b [4];
        int r0, t0, p0, nb, k;

        for (int i = 0; i < 64; i++) tx_arr[i] = 8'h00;
        repeat (4) @(negedge clk);

        check("rst_rx_data", 32'(bus_if.rx_data), 0);
        check("rst_rx_valid", 32'(bus_if.rx_valid), 0);
        check("rst_tx_load", 32'(bus_if.tx_load), 0);
        check("rst_rw", 32'(bus_if.rw), 0);
        check("rst_busy", 32'(bus_if.busy), 0);
        check("rst_sda", 32'(sda), 1);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // write 0xA5 to 0x42
        r0 = rx_cnt;
        m_start();
        m_write(8'h84, ack);
        check("t1_addr_ack", 32'(ack), 1);
        check("t1_busy", 32'(bus_if.busy), 1);
        check("t1_rw", 32'(bus_if.rw), 0);
        m_write(8'hA5, ack);
        check("t1_data_ack", 32'(ack), 1);
        check("t1_rx_data", 32'(bus_if.rx_data), 'hA5);
        check("t1_rx_pulses", 32'(rx_cnt - r0), 1);
        m_stop();
        repeat (4) @(negedge clk);
        check("t1_busy_stop", 32'(bus_if.busy), 0);
        check("t1_idle", 32'(dut.state_q), 32'(IDLE));

        // address mismatch
        t0 = tgt_low;
        r0 = rx_cnt;
        m_start();
        m_write(8'h86, ack);
        check("t2_addr_nack", 32'(ack), 0);
        check("t2_busy", 32'(bus_if.busy), 0);
        m_write(8'hFF, ack);
        check("t2_data_nack", 32'(ack), 0);
        m_stop();
        repeat (4) @(negedge clk);
        check("t2_no_drive", 32'(tgt_low - t0), 0);
        check("t2_no_rx", 32'(rx_cnt - r0), 0);
        check("t2_idle", 32'(dut.state_q), 32'(IDLE));

        // single-byte read, master NACK
        p0 = tx_pops;
        tx_arr[p0[5:0]] = 8'h3C;
        m_start();
        m_write(8'h85, ack);
        check("t3_addr_ack", 32'(ack), 1);
        check("t3_rw", 32'(bus_if.rw), 1);
        m_read(1'b0, d, s);
        check("t3_data", 32'(d), 'h3C);
        check("t3_ack_slot", 32'(s), 1);
        check("t3_tx_loads", 32'(tx_pops - p0), 1);
        check("t3_wait_stop", 32'(dut.state_q), 32'(WAIT_STOP));
        m_stop();
        repeat (4) @(negedge clk);
        check("t3_idle", 32'(dut.state_q), 32'(IDLE));

        // two-byte read, ACK then NACK
        p0 = tx_pops;
        k = p0 + 1;
        tx_arr[p0[5:0]] = 8'h11;
        tx_arr[k[5:0]] = 8'h22;
        m_start();
        m_write(8'h85, ack);
        check("t4_addr_ack", 32'(ack), 1);
        m_read(1'b1, d, s);
        check("t4_byte0", 32'(d), 'h11);
        m_read(1'b0, d, s);
        check("t4_byte1", 32'(d), 'h22);
        check("t4_nack_slot", 32'(s), 1);
        t0 = tgt_low;
        m_stop();
        repeat (4) @(negedge clk);
        check("t4_tx_loads", 32'(tx_pops - p0), 2);
        check("t4_no_drive", 32'(tgt_low - t0), 0);
        check("t4_busy", 32'(bus_if.busy), 0);

        // write then repeated START into a read
        m_start();
        m_write(8'h84, ack);
        m_write(8'h5A, ack);
        check("t5_wr_ack", 32'(ack), 1);
        p0 = tx_pops;
        tx_arr[p0[5:0]] = 8'hC3;
        m_start();
        m_write(8'h85, ack);
        check("t5_rd_addr_ack", 32'(ack), 1);
        check("t5_rw", 32'(bus_if.rw), 1);
        check("t5_rx_data", 32'(bus_if.rx_data), 'h5A);
        m_read(1'b0, d, s);
        check("t5_data", 32'(d), 'hC3);
        m_stop();

        // async reset while the target drives a 0 data bit
        p0 = tx_pops;
        tx_arr[p0[5:0]] = 8'hE7;
        m_start();
        m_write(8'h85, ack);
        for (int i = 0; i < 3; i++) m_bit(1'b1, g);
        wait_q();
        m_sda_low = 1'b0;
        wait_q();
        scl = 1'b1;
        wait_q();
        check("t6_driving", 32'(sda), 0);
        rst = 1'b1;
        #1;
        check("t6_sda_rel", 32'(sda), 1);
        check("t6_busy", 32'(bus_if.busy), 0);
        check("t6_rw", 32'(bus_if.rw), 0);
        check("t6_rx_data", 32'(bus_if.rx_data), 0);
        check("t6_tx_load", 32'(bus_if.tx_load), 0);
        check("t6_rx_valid", 32'(bus_if.rx_valid), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        t0 = tgt_low;
        r0 = rx_cnt;
        p0 = tx_pops;
        wait_q();
        scl = 1'b0;
        for (int i = 0; i < 12; i++) m_bit(1'($urandom_range(0, 1)), g);
        check("t6_ignore_drive", 32'(tgt_low - t0), 0);
        check("t6_ignore_rx", 32'(rx_cnt - r0), 0);
        check("t6_ignore_tx", 32'(tx_pops - p0), 0);
        check("t6_ignore_busy", 32'(bus_if.busy), 0);
        check("t6_ignore_idle", 32'(dut.state_q), 32'(IDLE));
        bv = 8'($urandom);
        m_start();
        m_write(8'h84, ack);
        check("t6_restart_ack", 32'(ack), 1);
        m_write(bv, ack);
        check("t6_restart_rx", 32'(bus_if.rx_data), 32'(bv));
        m_stop();

        // randomized transactions against expected-byte model
        for (int t = 0; t < 8; t++) begin
            is_rd = 1'($urandom_range(0, 1));
            nb = int'($urandom_range(1, 3));
            match = ($urandom_range(0, 3) != 0);
            a = 7'($urandom_range(0, 127));
            if (match) a = 7'h42;
            else if (a == 7'h42) a = 7'h13;
            m_start();
            m_write({a, is_rd}, ack);
            check("rnd_addr_ack", 32'(ack), 32'(match));
            if (!is_rd) begin
                r0 = rx_cnt;
                for (int b = 0; b < nb; b++) begin
                    bv = 8'($urandom);
                    m_write(bv, ack);
                    check("rnd_wr_ack", 32'(ack), 32'(match));
                    if (match) check("rnd_rx_data", 32'(bus_if.rx_data), 32'(bv));
                end
                check("rnd_rx_pulses", 32'(rx_cnt - r0), match ? nb : 0);
            end else begin
                p0 = tx_pops;
                for (int b = 0; b < nb; b++) begin
                    exp_b[b] = 8'($urandom);
                    k = p0 + b;
                    tx_arr[k[5:0]] = exp_b[b];
                end
                for (int b = 0; b < nb; b++) begin
                    m_read(b != nb - 1, d, s);
                    check("rnd_rd_data", 32'(d), match ? 32'(exp_b[b]) : 'hFF);
                end
                check("rnd_tx_loads", 32'(tx_pops - p0), match ? nb : 0);
            end
            m_stop();
            repeat (4) @(negedge clk);
            check("rnd_busy_end", 32'(bus_if.busy), 0);
        end

        check("no_overlap", 32'(overlap), 0);
        check("pulses_in_busy", 32'(outside), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
